// File: rtl/scm_read_port_pkg.sv
// Shared types for the SCM read-port controller: lane FSM states and
// response buffer depth.
package scm_read_port_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    WAIT_WR = 2'd2
  } lane_state_e;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/scm_read_port_lane.sv
// One SCM read lane: request issue, way select, write-collision stall and a
// 2-entry in-order response FIFO.
module scm_read_port_lane
  import scm_read_port_pkg::*;
#(
  parameter int NB_WAYS    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int WAY_W      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [WAY_W-1:0]                  req_way,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [DATA_WIDTH-1:0]             resp_data,
  output logic                              read_enable,
  output logic [ADDR_WIDTH-1:0]             read_addr,
  input  logic [NB_WAYS-1:0][DATA_WIDTH-1:0] read_data,
  input  logic                              wr_pend,
  input  logic [ADDR_WIDTH-1:0]             wr_addr
);

  lane_state_e                           state_q, state_d;
  logic [WAY_W-1:0]                      way_q;
  logic [ADDR_WIDTH-1:0]                 inflight_addr_q;
  logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0]  buf_q;
  logic                                  rd_ptr_q, wr_ptr_q;
  logic [1:0]                            cnt_q;
  logic                                  inflight, collision, pop, push, accept;
  logic [2:0]                            occ;

  assign inflight  = (state_q != IDLE);
  assign collision = wr_pend && (wr_addr == inflight_addr_q);
  assign pop       = resp_valid && resp_ready;
  assign occ       = 3'(cnt_q) + 3'(inflight) - 3'(pop);

  // A colliding DATA cycle must not accept: a new accept would move the SCM
  // address before the stalled word has been captured.
  assign req_ready = (occ < 3'(BUF_DEPTH)) && (state_q != WAIT_WR) &&
                     !((state_q == DATA) && collision);
  assign accept      = req_valid && req_ready;
  assign read_enable = accept;
  assign read_addr   = req_addr;

  assign resp_valid = (cnt_q != 2'd0);
  assign resp_data  = buf_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = DATA;
      DATA, WAIT_WR: begin
        if (collision) begin
          state_d = WAIT_WR;
        end else begin
          push    = 1'b1;
          state_d = accept ? DATA : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      way_q           <= '0;
      inflight_addr_q <= '0;
      buf_q           <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        way_q           <= req_way;
        inflight_addr_q <= req_addr;
      end
      if (push) begin
        buf_q[wr_ptr_q] <= read_data[way_q];
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (cnt_q < 2'(BUF_DEPTH)));

endmodule

// File: rtl/scm_read_port_ctrl.sv
// Read-side controller for the multi-way latch SCM: N_READ independent lanes
// sharing one registered snoop of the SCM write port.
module scm_read_port_ctrl
  import scm_read_port_pkg::*;
#(
  parameter int NB_WAYS    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2,
  parameter int WAY_W      = (NB_WAYS > 1) ? $clog2(NB_WAYS) : 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [N_READ-1:0]                             req_valid_i,
  output logic [N_READ-1:0]                             req_ready_o,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]             req_addr_i,
  input  logic [N_READ-1:0][WAY_W-1:0]                  req_way_i,
  output logic [N_READ-1:0]                             resp_valid_o,
  input  logic [N_READ-1:0]                             resp_ready_i,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]             resp_data_o,
  output logic [N_READ-1:0]                             ReadEnable_o,
  output logic [N_READ-1:0][ADDR_WIDTH-1:0]             ReadAddr_o,
  input  logic [NB_WAYS-1:0][N_READ-1:0][DATA_WIDTH-1:0] ReadData_i,
  input  logic                                          wr_en_i,
  input  logic [ADDR_WIDTH-1:0]                         wr_addr_i
);

  // Registered write snoop: high during the cycle the target latch is open.
  logic                  wr_pend_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_pend_q <= wr_en_i;
      wr_addr_q <= wr_addr_i;
    end
  end

  for (genvar p = 0; p < N_READ; p++) begin : g_lane
    logic [NB_WAYS-1:0][DATA_WIDTH-1:0] lane_rdata;
    for (genvar w = 0; w < NB_WAYS; w++) begin : g_way
      assign lane_rdata[w] = ReadData_i[w][p];
    end

    scm_read_port_lane #(
      .NB_WAYS   (NB_WAYS),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .WAY_W     (WAY_W)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid_i[p]),
      .req_ready  (req_ready_o[p]),
      .req_addr   (req_addr_i[p]),
      .req_way    (req_way_i[p]),
      .resp_valid (resp_valid_o[p]),
      .resp_ready (resp_ready_i[p]),
      .resp_data  (resp_data_o[p]),
      .read_enable(ReadEnable_o[p]),
      .read_addr  (ReadAddr_o[p]),
      .read_data  (lane_rdata),
      .wr_pend    (wr_pend_q),
      .wr_addr    (wr_addr_q)
    );
  end

endmodule

// File: tb/tb_scm_read_port_ctrl.sv
// Bench for scm_read_port_ctrl: latch-SCM model, directed vector table,
// hand sequences and a randomized scoreboard run.
module tb_scm_read_port_ctrl;
  localparam int NB_WAYS = 4, AW = 5, DW = 32, NR = 2, WAY_W = 2;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic clk = 1'b0, rst_n;
  logic [NR-1:0] req_valid, req_ready, resp_valid, resp_ready, read_en;
  logic [NR-1:0][AW-1:0] req_addr, read_addr;
  logic [NR-1:0][WAY_W-1:0] req_way;
  logic [NR-1:0][DW-1:0] resp_data;
  logic [NB_WAYS-1:0][NR-1:0][DW-1:0] read_data;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [WAY_W-1:0] wr_way;
  logic [DW-1:0] wr_data;

  always #5 clk = ~clk;

  scm_read_port_ctrl #(.NB_WAYS(NB_WAYS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_way_i(req_way),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .ReadEnable_o(read_en), .ReadAddr_o(read_addr), .ReadData_i(read_data),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr));

  // Latch SCM model: write registered at an edge, latch open (garbage) for the
  // following cycle, new value settled from the edge after.
  logic [DW-1:0] mem [NB_WAYS][1<<AW];
  logic [NR-1:0][AW-1:0] raddr_q = '0;
  logic wp_pend = 1'b0;
  logic [AW-1:0] wp_addr = '0;
  logic [WAY_W-1:0] wp_way = '0;
  logic [DW-1:0] wp_data = '0;
  logic init_req, bd_en;
  logic [AW-1:0] bd_addr;
  logic [WAY_W-1:0] bd_way;
  logic [DW-1:0] bd_data;

  function automatic logic [31:0] enc(input int w, input int a, input int v);
    return {1'b0, 7'(v), 8'(w), 16'(a)};
  endfunction

  always @(posedge clk) begin
    if (init_req)
      for (int w = 0; w < NB_WAYS; w++)
        for (int a = 0; a < (1<<AW); a++) mem[w][a] <= enc(w, a, 0);
    if (bd_en) mem[bd_way][bd_addr] <= bd_data;
    if (wp_pend) mem[wp_way][wp_addr] <= wp_data;
    for (int p = 0; p < NR; p++) if (read_en[p]) raddr_q[p] <= read_addr[p];
    wp_pend <= wr_en; wp_addr <= wr_addr; wp_way <= wr_way; wp_data <= wr_data;
  end

  always_comb begin
    for (int w = 0; w < NB_WAYS; w++)
      for (int p = 0; p < NR; p++)
        read_data[w][p] = (wp_pend && wp_way == WAY_W'(w) && wp_addr == raddr_q[p]) ?
                          GARBAGE : mem[w][raddr_q[p]];
  end

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Single read with an optional write issued at the accept edge.
  task automatic one_read(input int p, input int a, input int w, input logic [31:0] pre,
                          input logic do_wr, input int wa, input int ww, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_d);
    int lat;
    bd_en = 1'b1; bd_way = WAY_W'(w); bd_addr = AW'(a); bd_data = pre;
    nxt();
    bd_en = 1'b0;
    resp_ready = '1; req_valid = '0;
    req_valid[p] = 1'b1; req_addr[p] = AW'(a); req_way[p] = WAY_W'(w);
    wr_en = do_wr; wr_addr = AW'(wa); wr_way = WAY_W'(ww); wr_data = wd;
    @(negedge clk);
    chk("vec_ready", 32'(req_ready[p]), 32'd1);
    chk("vec_read_addr", 32'(read_addr[p]), 32'(a));
    nxt();
    req_valid = '0; wr_en = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid[p] && lat < 8) begin
      nxt(); lat++; @(negedge clk);
    end
    chk("vec_latency", 32'(lat), 32'(exp_lat));
    chk("vec_data", resp_data[p], exp_d);
    nxt();
    @(negedge clk);
    chk("vec_drained", 32'(resp_valid[p]), 32'd0);
    nxt();
  endtask

  typedef struct {
    int port; int addr; int way; logic [31:0] pre;
    logic do_wr; int wa; int ww; logic [31:0] wd;
    int lat; logic [31:0] exp_d;
  } vec_t;
  vec_t vecs[6];

  typedef struct { int way; int addr; int minv; } exp_t;
  exp_t sb[NR][$];
  int ver[NB_WAYS][1<<AW];

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    int n_req, n_resp, n_acc, first, last;
    logic [31:0] d;
    exp_t e;
    logic ok;
    logic [NR-1:0] hold;
    logic [NR-1:0][31:0] hold_d;

    vecs[0] = '{0,  3, 2, 32'hA5A5_0003, 1'b0, 0,  0, 32'h0,         2, 32'hA5A5_0003};
    vecs[1] = '{1,  5, 1, 32'h1234_5678, 1'b1, 6,  1, 32'h0BAD_0006, 2, 32'h1234_5678};
    vecs[2] = '{0,  5, 1, 32'h1111_0005, 1'b1, 5,  1, 32'h2222_0005, 3, 32'h2222_0005};
    vecs[3] = '{1,  0, 3, 32'h3333_0000, 1'b1, 0,  1, 32'h4444_0000, 3, 32'h3333_0000};
    vecs[4] = '{1, 31, 3, 32'h5555_001F, 1'b0, 0,  0, 32'h0,         2, 32'h5555_001F};
    vecs[5] = '{0, 31, 0, 32'h7777_001F, 1'b1, 30, 0, 32'h0BAD_001E, 2, 32'h7777_001F};

    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_way = '0; resp_ready = '0;
    wr_en = 1'b0; wr_addr = '0; wr_way = '0; wr_data = '0;
    init_req = 1'b0; bd_en = 1'b0; bd_addr = '0; bd_way = '0; bd_data = '0;
    repeat (2) nxt();
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd3);
    chk("rst_read_en", 32'(read_en), 32'd0);
    chk("rst_resp_data0", resp_data[0], 32'd0);
    nxt(); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd3);
    nxt();
    init_req = 1'b1; nxt(); init_req = 1'b0;

    foreach (vecs[i])
      one_read(vecs[i].port, vecs[i].addr, vecs[i].way, vecs[i].pre, vecs[i].do_wr,
               vecs[i].wa, vecs[i].ww, vecs[i].wd, vecs[i].lat, vecs[i].exp_d);

    // Streaming on port 1
    resp_ready = '1; n_req = 0; n_resp = 0; first = -1; last = -1;
    for (int c = 0; c < 14; c++) begin
      req_valid = '0; req_valid[1] = (n_req < 8);
      req_addr[1] = AW'(n_req); req_way[1] = '0;
      @(negedge clk);
      if (req_valid[1]) begin
        chk("stream_ready", 32'(req_ready[1]), 32'd1);
        if (req_ready[1]) n_req++;
      end
      if (resp_valid[1]) begin
        chk("stream_data", resp_data[1], enc(0, n_resp, 0));
        if (first < 0) first = c;
        last = c; n_resp++;
      end
      nxt();
    end
    chk("stream_count", 32'(n_resp), 32'd8);
    chk("stream_consecutive", 32'(last - first), 32'd7);

    // Backpressure on port 0
    req_valid = '0; resp_ready = '0; n_acc = 0;
    for (int c = 0; c < 5; c++) begin
      req_valid[0] = 1'b1; req_addr[0] = AW'(10 + n_acc); req_way[0] = '0;
      @(negedge clk);
      if (c >= 3) begin
        chk("bp_valid", 32'(resp_valid[0]), 32'd1);
        chk("bp_stable_data", resp_data[0], enc(0, 10, 0));
      end
      if (c == 4) chk("bp_ready_low", 32'(req_ready[0]), 32'd0);
      if (req_ready[0]) n_acc++;
      nxt();
    end
    chk("bp_accepted", 32'(n_acc), 32'd2);
    resp_ready[0] = 1'b1; n_resp = 0;
    for (int c = 0; c < 20 && n_resp < 4; c++) begin
      req_valid[0] = (n_acc < 4); req_addr[0] = AW'(10 + n_acc);
      @(negedge clk);
      if (resp_valid[0]) begin
        chk("bp_drain_data", resp_data[0], enc(0, 10 + n_resp, 0));
        n_resp++;
      end
      if (req_valid[0] && req_ready[0]) n_acc++;
      nxt();
    end
    req_valid = '0;
    chk("bp_drain_count", 32'(n_resp), 32'd4);
    repeat (2) nxt();

    // Reset mid-operation: port 1 two buffered, port 0 one buffered + one in flight
    resp_ready = '0;
    for (int c = 0; c < 4; c++) begin
      req_valid[1] = 1'b1; req_addr[1] = 5'd20; req_way[1] = '0;
      req_valid[0] = (c >= 2); req_addr[0] = 5'd21; req_way[0] = '0;
      nxt();
    end
    req_valid = '0;
    @(negedge clk);
    chk("midrst_pre_valid", 32'(resp_valid), 32'd3);
    rst_n = 1'b0; #1;
    chk("midrst_valid_low", 32'(resp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd3);
    repeat (2) nxt();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_nothing_emitted", 32'(resp_valid), 32'd0);
      nxt();
    end
    one_read(0, 25, 1, 32'h6666_0019, 1'b0, 0, 0, 32'h0, 2, 32'h6666_0019);

    // Randomized run against the scoreboard
    init_req = 1'b1; nxt(); init_req = 1'b0;
    foreach (ver[w, a]) ver[w][a] = 0;
    hold = '0; hold_d = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic drain;
      drain = (cyc >= 760);
      for (int p = 0; p < NR; p++) begin
        req_valid[p]  = !drain && ($urandom_range(0, 99) < 60);
        req_addr[p]   = AW'($urandom_range(0, 7));
        req_way[p]    = WAY_W'($urandom_range(0, NB_WAYS - 1));
        resp_ready[p] = drain || ($urandom_range(0, 99) < 70);
      end
      wr_en = !drain && ($urandom_range(0, 99) < 40);
      wr_addr = AW'($urandom_range(0, 7));
      wr_way = WAY_W'($urandom_range(0, NB_WAYS - 1));
      wr_data = enc(int'(wr_way), int'(wr_addr), ver[wr_way][wr_addr] + 1);
      @(negedge clk);
      for (int p = 0; p < NR; p++) begin
        if (hold[p]) begin
          chk("rnd_hold_valid", 32'(resp_valid[p]), 32'd1);
          chk("rnd_hold_data", resp_data[p], hold_d[p]);
        end
        chk("rnd_read_en", 32'(read_en[p]), 32'(req_valid[p] & req_ready[p]));
        if (resp_valid[p] && resp_ready[p]) begin
          if (sb[p].size() == 0) begin
            chk("rnd_spurious_resp", 32'(resp_valid[p]), 32'd0);
          end else begin
            e = sb[p].pop_front();
            d = resp_data[p];
            ok = !d[31] && d[23:16] == 8'(e.way) && d[15:0] == 16'(e.addr) &&
                 int'(d[30:24]) >= e.minv && int'(d[30:24]) <= ver[e.way][e.addr];
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL rnd_data port %0d actual=%h required way %0d addr %0d version %0d..%0d",
                       p, d, e.way, e.addr, e.minv, ver[e.way][e.addr]);
            end
          end
        end
        if (req_valid[p] && req_ready[p]) begin
          e.way = int'(req_way[p]); e.addr = int'(req_addr[p]);
          e.minv = ver[e.way][e.addr] +
                   ((wr_en && wr_way == req_way[p] && wr_addr == req_addr[p]) ? 1 : 0);
          sb[p].push_back(e);
          chk("rnd_occupancy", 32'(sb[p].size() <= 2), 32'd1);
        end
        hold[p] = resp_valid[p] && !resp_ready[p];
        hold_d[p] = resp_data[p];
      end
      if (wr_en) ver[wr_way][wr_addr]++;
      nxt();
    end
    wr_en = 1'b0; req_valid = '0;
    for (int p = 0; p < NR; p++) chk("rnd_all_returned", 32'(sb[p].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
